ram_arbiter: RTL and testbench

- Shares the CPU's single-port 128x8 data RAM between two requesters: the CPU execute state and the UART byte-DMA engine.
- The CPU has absolute priority and is never stalled. The DMA side uses a req/gnt/done handshake.
- DMA accesses are latched and replayed in the first cycle in which the CPU is not using the RAM.
- The block sits between the CPU datapath/controller and single_port_ram_128x8, and drives that RAM's data/addr/ram_en pins.

---
 rtl/ram_arbiter_if.sv | 49 ++++
 rtl/ram_arbiter.sv | 137 +++++++++++++
 tb/tb_ram_arbiter.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// Bus bundle between the RAM arbiter, its two requesters (CPU execute
// state, UART byte-DMA) and the single-port 128x8 data RAM.
interface ram_arbiter_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
);
  // CPU side: owns the RAM whenever cpu_req is high
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;

  // DMA side: req/gnt/done handshake
  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic              dma_done;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_starve;

  // RAM pins
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic              ram_en;
  logic [DATA_W-1:0] ram_q;

  // Arbiter view
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_done, dma_rdata, dma_starve,
    output ram_addr, ram_data, ram_en,
    input  ram_q
  );

  // Requester / RAM-model view
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_done, dma_rdata, dma_starve,
    input  ram_addr, ram_data, ram_en,
    output ram_q
  );
endinterface

// File: rtl/ram_arbiter.sv
// Shares the single-port data RAM between the CPU (absolute priority,
// zero added latency) and the UART byte-DMA engine. A DMA access is
// latched at grant and replayed in the first cycle the CPU leaves the
// RAM free; a saturating wait counter flags DMA starvation.
module ram_arbiter #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 12
) (
  input logic          clk,
  input logic          rst,
  ram_arbiter_if.slave bus
);

  localparam int              CNT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q,    we_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]  wait_q,  wait_d;
  logic              starve_q, starve_d;
  logic              gnt, done;
  logic              dma_drive;

  // Saturating increment of the wait counter.
  function automatic logic [CNT_W-1:0] wait_inc(input logic [CNT_W-1:0] w);
    return (w == WAIT_MAX) ? w : w + CNT_W'(1);
  endfunction

  // Next-state and handshake decode.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    rdata_d  = rdata_q;
    wait_d   = wait_q;
    starve_d = starve_q;
    gnt      = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.dma_req) begin
          wait_d = wait_inc(wait_q);
          if (!bus.cpu_req) begin
            gnt     = 1'b1;
            addr_d  = bus.dma_addr;
            wdata_d = bus.dma_wdata;
            we_d    = bus.dma_we;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (bus.cpu_req) begin
          // CPU keeps the RAM; the latched access waits.
          wait_d = wait_inc(wait_q);
        end else begin
          if (!we_q) rdata_d = bus.ram_q;
          wait_d  = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (wait_d == WAIT_MAX) starve_d = 1'b1;
  end

  // State and datapath registers; reset aborts any in-flight access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      rdata_q  <= '0;
      wait_q   <= '0;
      starve_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      rdata_q  <= rdata_d;
      wait_q   <= wait_d;
      starve_q <= starve_d;
    end
  end

  // DMA owns the RAM pins only in ACCESS, outside reset, with the CPU idle;
  // gating on rst keeps a reset-in-ACCESS from committing the write.
  assign dma_drive = (state_q == ACCESS) && !bus.cpu_req && !rst;

  // RAM mux: CPU first, then the replayed DMA access, else parked at zero.
  always_comb begin
    bus.ram_addr = '0;
    bus.ram_data = '0;
    bus.ram_en   = 1'b0;
    if (bus.cpu_req) begin
      bus.ram_addr = bus.cpu_addr;
      bus.ram_data = bus.cpu_wdata;
      bus.ram_en   = bus.cpu_we;
    end else if (dma_drive) begin
      bus.ram_addr = addr_q;
      bus.ram_data = wdata_q;
      bus.ram_en   = we_q;
    end
  end

  assign bus.cpu_rdata  = bus.ram_q;
  assign bus.dma_gnt    = gnt  & ~rst;
  assign bus.dma_done   = done & ~rst;
  assign bus.dma_rdata  = rdata_q;
  assign bus.dma_starve = starve_q;

  // Grant and done come from different states, so they can never overlap.
  a_gnt_done_excl: assert property (@(posedge clk) disable iff (rst)
    !(bus.dma_gnt && bus.dma_done));

  // Starvation flag is sticky until reset.
  a_starve_sticky: assert property (@(posedge clk) disable iff (rst)
    bus.dma_starve |=> bus.dma_starve);

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural 128x8 RAM, reference memory image and
// a queue of expected dma_rdata values pushed at grant, popped at done.
module tb_ram_arbiter;
  localparam int AW = 7;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst;
  logic mem_load;
  int   total = 0;
  int   bad   = 0;

  logic [DW-1:0] mem     [0:127];
  logic [DW-1:0] ref_mem [0:127];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] last_rdata;

  ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Single-port RAM: combinational read, write on posedge.
  assign bus.ram_q = mem[bus.ram_addr];
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 128; i++) mem[i] <= 8'(i) ^ 8'h3C;
    end else if (bus.ram_en) begin
      mem[bus.ram_addr] <= bus.ram_data;
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_load = 1'b1; idle_inputs();
    for (int i = 0; i < 128; i++) ref_mem[i] = 8'(i) ^ 8'h3C;
    last_rdata = '0;
    cyc(); cyc();
    mem_load = 1'b0;
    bus.dma_req = 1'b1;  // request during reset must not be granted
    @(negedge clk);
    total++; if (bus.dma_gnt !== 1'b0) begin bad++; $display("FAIL reset_gnt got=%0b exp=0", bus.dma_gnt); end
    total++; if (bus.dma_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b exp=0", bus.dma_done); end
    total++; if (bus.dma_rdata !== 8'h00) begin bad++; $display("FAIL reset_rdata got=%h exp=00", bus.dma_rdata); end
    total++; if (bus.dma_starve !== 1'b0) begin bad++; $display("FAIL reset_starve got=%0b exp=0", bus.dma_starve); end
    total++; if (bus.ram_en !== 1'b0 || bus.ram_addr !== 7'h00 || bus.ram_data !== 8'h00) begin
      bad++; $display("FAIL reset_ram en=%0b addr=%h data=%h exp 0/00/00", bus.ram_en, bus.ram_addr, bus.ram_data); end
    cyc();
    rst = 1'b0; bus.dma_req = 1'b0;
  endtask

  task automatic test_dma_write();
    logic [DW-1:0] e;
    bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 7'h20; bus.dma_wdata = 8'h5A;
    @(negedge clk);
    total++; if (bus.dma_gnt !== 1'b1) begin bad++; $display("FAIL wr_gnt_c0 got=%0b exp=1", bus.dma_gnt); end
    ref_mem[7'h20] = 8'h5A; exp_q.push_back(last_rdata);
    cyc();
    // drop req and scramble the request fields: the latched copy must be used
    bus.dma_req = 1'b0; bus.dma_addr = 7'h00; bus.dma_wdata = 8'hFF;
    @(negedge clk);
    total++; if (bus.ram_en !== 1'b1 || bus.ram_addr !== 7'h20 || bus.ram_data !== 8'h5A) begin
      bad++; $display("FAIL wr_ram_c1 en=%0b addr=%h data=%h exp 1/20/5a", bus.ram_en, bus.ram_addr, bus.ram_data); end
    total++; if (bus.dma_gnt !== 1'b0 || bus.dma_done !== 1'b0) begin
      bad++; $display("FAIL wr_hs_c1 gnt=%0b done=%0b exp 0/0", bus.dma_gnt, bus.dma_done); end
    cyc(); @(negedge clk);
    total++; if (bus.dma_done !== 1'b1) begin bad++; $display("FAIL wr_done_c2 got=%0b exp=1", bus.dma_done); end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++; if (bus.dma_rdata !== e) begin bad++; $display("FAIL wr_rdata got=%h exp=%h", bus.dma_rdata, e); end
    end
    cyc();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 7'h20;
    @(negedge clk);
    total++; if (bus.cpu_rdata !== ref_mem[7'h20]) begin bad++; $display("FAIL wr_cpu_readback got=%h exp=%h", bus.cpu_rdata, ref_mem[7'h20]); end
    cyc();
    idle_inputs();
  endtask

  task automatic test_read_deferred();
    logic [DW-1:0] e;
    logic [AW-1:0] ca;
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 7'h20;
    @(negedge clk);
    total++; if (bus.dma_gnt !== 1'b1) begin bad++; $display("FAIL rd_gnt got=%0b exp=1", bus.dma_gnt); end
    exp_q.push_back(ref_mem[7'h20]); last_rdata = ref_mem[7'h20];
    cyc();
    bus.dma_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ca = 7'h41 + 7'(k);
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = ca;
      @(negedge clk);
      total++; if (bus.ram_addr !== ca || bus.dma_done !== 1'b0) begin
        bad++; $display("FAIL rd_cpu_hold%0d addr=%h done=%0b exp %h/0", k, bus.ram_addr, bus.dma_done, ca); end
      cyc();
    end
    bus.cpu_req = 1'b0; bus.cpu_addr = '0;
    @(negedge clk);
    total++; if (bus.ram_addr !== 7'h20 || bus.ram_en !== 1'b0) begin
      bad++; $display("FAIL rd_access addr=%h en=%0b exp 20/0", bus.ram_addr, bus.ram_en); end
    cyc(); @(negedge clk);
    total++; if (bus.dma_done !== 1'b1) begin bad++; $display("FAIL rd_done_c5 got=%0b exp=1", bus.dma_done); end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++; if (bus.dma_rdata !== e) begin bad++; $display("FAIL rd_rdata got=%h exp=%h", bus.dma_rdata, e); end
    end
    cyc();
  endtask

  task automatic test_collision();
    logic [DW-1:0] e;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 7'h30; bus.cpu_wdata = 8'h11;
    bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 7'h30; bus.dma_wdata = 8'h22;
    @(negedge clk);
    total++; if (bus.dma_gnt !== 1'b0 || bus.ram_en !== 1'b1 || bus.ram_data !== 8'h11) begin
      bad++; $display("FAIL col_cpu_first gnt=%0b en=%0b data=%h exp 0/1/11", bus.dma_gnt, bus.ram_en, bus.ram_data); end
    cyc();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
    @(negedge clk);
    total++; if (bus.dma_gnt !== 1'b1) begin bad++; $display("FAIL col_gnt got=%0b exp=1", bus.dma_gnt); end
    ref_mem[7'h30] = 8'h22; exp_q.push_back(last_rdata);
    cyc();
    bus.dma_req = 1'b0;
    @(negedge clk);
    total++; if (bus.ram_en !== 1'b1 || bus.ram_data !== 8'h22) begin
      bad++; $display("FAIL col_dma_wr en=%0b data=%h exp 1/22", bus.ram_en, bus.ram_data); end
    cyc(); @(negedge clk);
    total++; if (bus.dma_done !== 1'b1) begin bad++; $display("FAIL col_done got=%0b exp=1", bus.dma_done); end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++; if (bus.dma_rdata !== e) begin bad++; $display("FAIL col_rdata got=%h exp=%h", bus.dma_rdata, e); end
    end
    cyc();
    bus.cpu_req = 1'b1; bus.cpu_addr = 7'h30;
    @(negedge clk);
    total++; if (bus.cpu_rdata !== ref_mem[7'h30]) begin bad++; $display("FAIL col_final got=%h exp=%h", bus.cpu_rdata, ref_mem[7'h30]); end
    cyc();
    // DMA read granted, then CPU writes the same address during ACCESS
    bus.cpu_req = 1'b0;
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 7'h31;
    @(negedge clk);
    total++; if (bus.dma_gnt !== 1'b1) begin bad++; $display("FAIL rdw_gnt got=%0b exp=1", bus.dma_gnt); end
    cyc();
    bus.dma_req = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 7'h31; bus.cpu_wdata = 8'h77;
    ref_mem[7'h31] = 8'h77; exp_q.push_back(8'h77); last_rdata = 8'h77;
    @(negedge clk);
    total++; if (bus.dma_done !== 1'b0 || bus.ram_data !== 8'h77) begin
      bad++; $display("FAIL rdw_cpu done=%0b data=%h exp 0/77", bus.dma_done, bus.ram_data); end
    cyc();
    idle_inputs();
    cyc(); @(negedge clk);
    total++; if (bus.dma_done !== 1'b1) begin bad++; $display("FAIL rdw_done got=%0b exp=1", bus.dma_done); end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++; if (bus.dma_rdata !== e) begin bad++; $display("FAIL rdw_rdata got=%h exp=%h", bus.dma_rdata, e); end
    end
    cyc();
  endtask

  task automatic test_starve();
    logic [DW-1:0] e;
    int n;
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 7'h05;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 7'h00;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      total++; if (bus.dma_starve !== 1'b0 || bus.dma_gnt !== 1'b0) begin
        bad++; $display("FAIL starve_early c=%0d starve=%0b gnt=%0b exp 0/0", c, bus.dma_starve, bus.dma_gnt); end
      cyc();
    end
    bus.cpu_req = 1'b0;
    @(negedge clk);
    total++; if (bus.dma_starve !== 1'b1 || bus.dma_gnt !== 1'b1) begin
      bad++; $display("FAIL starve_c12 starve=%0b gnt=%0b exp 1/1", bus.dma_starve, bus.dma_gnt); end
    exp_q.push_back(ref_mem[7'h05]); last_rdata = ref_mem[7'h05];
    cyc();
    bus.dma_req = 1'b0;
    n = 0;
    @(negedge clk);
    while (bus.dma_done !== 1'b1 && n < 10) begin cyc(); @(negedge clk); n++; end
    total++; if (bus.dma_done !== 1'b1) begin bad++; $display("FAIL starve_done_timeout got=%0b exp=1", bus.dma_done); end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++; if (bus.dma_rdata !== e) begin bad++; $display("FAIL starve_rdata got=%h exp=%h", bus.dma_rdata, e); end
    end
    cyc(); cyc(); @(negedge clk);
    total++; if (bus.dma_starve !== 1'b1) begin bad++; $display("FAIL starve_sticky got=%0b exp=1", bus.dma_starve); end
    rst = 1'b1;
    cyc();
    rst = 1'b0; last_rdata = '0;
    @(negedge clk);
    total++; if (bus.dma_starve !== 1'b0 || bus.dma_rdata !== 8'h00) begin
      bad++; $display("FAIL starve_clear starve=%0b rdata=%h exp 0/00", bus.dma_starve, bus.dma_rdata); end
    cyc();
  endtask

  task automatic test_reset_mid_access();
    bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 7'h05; bus.dma_wdata = 8'h7F;
    @(negedge clk);
    total++; if (bus.dma_gnt !== 1'b1) begin bad++; $display("FAIL rma_gnt got=%0b exp=1", bus.dma_gnt); end
    cyc();
    bus.dma_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    total++; if (bus.ram_en !== 1'b0 || bus.dma_done !== 1'b0 || bus.dma_gnt !== 1'b0) begin
      bad++; $display("FAIL rma_access en=%0b done=%0b gnt=%0b exp 0/0/0", bus.ram_en, bus.dma_done, bus.dma_gnt); end
    cyc();
    rst = 1'b0;
    @(negedge clk);
    total++; if (bus.dma_done !== 1'b0 || bus.dma_rdata !== 8'h00 || bus.dma_starve !== 1'b0 || bus.ram_en !== 1'b0) begin
      bad++; $display("FAIL rma_after done=%0b rdata=%h starve=%0b en=%0b exp 0/00/0/0",
                      bus.dma_done, bus.dma_rdata, bus.dma_starve, bus.ram_en); end
    cyc();
    bus.cpu_req = 1'b1; bus.cpu_addr = 7'h05;
    @(negedge clk);
    total++; if (bus.cpu_rdata !== ref_mem[7'h05]) begin bad++; $display("FAIL rma_mem got=%h exp=%h", bus.cpu_rdata, ref_mem[7'h05]); end
    cyc();
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] e;
    int g;
    bus.dma_req = 1'b1; bus.dma_we = 1'b1;
    for (int c = 0; c < 9; c++) begin
      g = c / 3;
      bus.dma_addr = 7'h40 + 7'(g); bus.dma_wdata = 8'h90 + 8'(g * 3);
      @(negedge clk);
      total++; if (bus.dma_gnt !== (c % 3 == 0) || bus.dma_done !== (c % 3 == 2)) begin
        bad++; $display("FAIL b2b_c%0d gnt=%0b done=%0b exp %0b/%0b", c, bus.dma_gnt, bus.dma_done, c % 3 == 0, c % 3 == 2); end
      if (bus.dma_gnt === 1'b1) begin
        ref_mem[7'h40 + 7'(g)] = 8'h90 + 8'(g * 3); exp_q.push_back(last_rdata);
      end
      if (bus.dma_done === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++; if (bus.dma_rdata !== e) begin bad++; $display("FAIL b2b_rdata c=%0d got=%h exp=%h", c, bus.dma_rdata, e); end
      end
      cyc();
    end
    idle_inputs();
    for (int a = 0; a < 3; a++) begin
      bus.cpu_req = 1'b1; bus.cpu_addr = 7'h40 + 7'(a);
      @(negedge clk);
      total++; if (bus.cpu_rdata !== ref_mem[7'h40 + 7'(a)]) begin
        bad++; $display("FAIL b2b_mem%0d got=%h exp=%h", a, bus.cpu_rdata, ref_mem[7'h40 + 7'(a)]); end
      cyc();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_dma_write();
    test_read_deferred();
    test_collision();
    test_starve();
    test_reset_mid_access();
    test_back_to_back();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
